// File: rtl/lcd_bus_monitor_pkg.sv
// Shared types, opcode constants and DDRAM address helpers for the LCD bus monitor.
// The 4x20 panel maps two 40-byte DDRAM lines onto four visible rows.
package lcd_pkg;

    localparam int SCREEN_CELLS = 80;

    localparam logic [6:0] ROW0_LAST  = 7'h13;
    localparam logic [6:0] ROW2_FIRST = 7'h14;
    localparam logic [6:0] ROW2_LAST  = 7'h27;
    localparam logic [6:0] ROW1_FIRST = 7'h40;
    localparam logic [6:0] ROW1_LAST  = 7'h53;
    localparam logic [6:0] ROW3_FIRST = 7'h54;
    localparam logic [6:0] ROW3_LAST  = 7'h67;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    typedef enum logic [3:0] {
        CMD_NOP, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPLAY,
        CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM
    } cmd_e;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] dat;
    } bus_s;

    // The highest set bit selects the instruction class.
    function automatic cmd_e decode_cmd(input logic [7:0] op);
        if ((op & OP_DDRAM) != 8'h00)        return CMD_DDRAM;
        else if ((op & OP_CGRAM) != 8'h00)   return CMD_CGRAM;
        else if ((op & OP_FUNC) != 8'h00)    return CMD_FUNC;
        else if ((op & OP_SHIFT) != 8'h00)   return CMD_SHIFT;
        else if ((op & OP_DISPLAY) != 8'h00) return CMD_DISPLAY;
        else if ((op & OP_ENTRY) != 8'h00)   return CMD_ENTRY;
        else if ((op & OP_HOME) != 8'h00)    return CMD_HOME;
        else if ((op & OP_CLEAR) != 8'h00)   return CMD_CLEAR;
        else                                 return CMD_NOP;
    endfunction

    function automatic logic ddram_valid(input logic [6:0] a);
        return (a <= ROW2_LAST) || ((a >= ROW1_FIRST) && (a <= ROW3_LAST));
    endfunction

    function automatic logic [6:0] ddram_to_idx(input logic [6:0] a);
        if (a <= ROW0_LAST)                            return a;
        else if (a <= ROW2_LAST)                       return a - ROW2_FIRST + 7'd40;
        else if ((a >= ROW1_FIRST) && (a <= ROW1_LAST)) return a - ROW1_FIRST + 7'd20;
        else if ((a >= ROW3_FIRST) && (a <= ROW3_LAST)) return a - ROW3_FIRST + 7'd60;
        else                                           return 7'd0;
    endfunction

    function automatic logic [6:0] cursor_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == ROW2_LAST)      return ROW1_FIRST;
            else if (a == ROW3_LAST) return 7'h00;
            else                     return a + 7'd1;
        end else begin
            if (a == ROW1_FIRST)     return ROW2_LAST;
            else if (a == 7'h00)     return ROW3_LAST;
            else                     return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_bus_monitor_if.sv
// HD44780 parallel bus as seen by the controller (master) and by passive listeners (slave).
interface lcd_bus_monitor_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_dat;

    modport master (output lcd_en, output lcd_rs, output lcd_rw, output lcd_dat);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_rw, input  lcd_dat);
endinterface

// File: rtl/lcd_bus_monitor_ddram.sv
// Shadow screen storage: 80x8, one synchronous write and one synchronous read port.
// A same-cycle read of the cell being written returns the previous contents.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [SCREEN_CELLS];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus listener keeping a shadow copy of the 4x20 screen and controller state.
// Bus inputs are resynchronised; a write is recognised one stage after en is seen falling.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_monitor_if.slave bus,
    input  logic [6:0]       rd_idx,
    output logic [7:0]       rd_char,
    output logic [6:0]       cursor,
    output logic             disp_on,
    output logic             entry_inc,
    output logic             func_ok,
    output logic             busy,
    output logic             cmd_strobe,
    output logic             data_strobe,
    output logic             err_addr,
    output logic [7:0]       drop_cnt
);

    localparam logic [6:0] LAST_CELL = 7'(SCREEN_CELLS - 1);

    bus_s   w_bus_in;
    bus_s   r_s1, r_s2, r_d;
    logic   w_evt;
    cmd_e   w_cmd;
    logic   w_we;
    logic [6:0] w_waddr, w_raddr;
    logic [7:0] w_wdata, w_mem_q;

    state_e     r_state;
    logic [6:0] r_clr_idx;
    logic       r_busy;
    logic [6:0] r_cursor;
    logic       r_disp_on, r_entry_inc, r_func_ok;
    logic       r_cmd_strobe, r_data_strobe, r_err_addr;
    logic [7:0] r_drop_cnt;
    logic       r_oob;

    assign w_bus_in = {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_dat};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_d  <= '0;
        end else begin
            r_s1 <= w_bus_in;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    // r_d still carries the fields that were stable while en was high.
    assign w_evt = r_d.en & ~r_s2.en & ~r_d.rw;
    assign w_cmd = decode_cmd(r_d.dat);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_idx;
        w_wdata = CLEAR_CHAR;
        if (r_state == ST_CLEAR) begin
            w_we = 1'b1;
        end else if (w_evt && r_d.rs) begin
            w_we    = 1'b1;
            w_waddr = ddram_to_idx(r_cursor);
            w_wdata = r_d.dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_CLEAR;
            r_clr_idx     <= '0;
            r_busy        <= 1'b1;
            r_cursor      <= '0;
            r_disp_on     <= 1'b0;
            r_entry_inc   <= 1'b1;
            r_func_ok     <= 1'b0;
            r_cmd_strobe  <= 1'b0;
            r_data_strobe <= 1'b0;
            r_err_addr    <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_cmd_strobe  <= 1'b0;
            r_data_strobe <= 1'b0;
            r_err_addr    <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (w_evt && (r_drop_cnt != 8'hFF)) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                    if (r_clr_idx == LAST_CELL) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_clr_idx <= r_clr_idx + 7'd1;
                end
                ST_IDLE: begin
                    if (w_evt && r_d.rs) begin
                        r_data_strobe <= 1'b1;
                        r_cursor      <= cursor_step(r_cursor, r_entry_inc);
                    end else if (w_evt) begin
                        r_cmd_strobe <= 1'b1;
                        case (w_cmd)
                            CMD_CLEAR: begin
                                r_state     <= ST_CLEAR;
                                r_clr_idx   <= '0;
                                r_busy      <= 1'b1;
                                r_cursor    <= '0;
                                r_entry_inc <= 1'b1;
                            end
                            CMD_HOME:    r_cursor    <= '0;
                            CMD_ENTRY:   r_entry_inc <= r_d.dat[1];
                            CMD_DISPLAY: r_disp_on   <= r_d.dat[2];
                            CMD_SHIFT: begin
                                if (!r_d.dat[3]) begin
                                    r_cursor <= cursor_step(r_cursor, r_d.dat[2]);
                                end
                            end
                            CMD_FUNC:    r_func_ok   <= r_d.dat[4] & r_d.dat[3];
                            CMD_DDRAM: begin
                                if (ddram_valid(r_d.dat[6:0])) begin
                                    r_cursor <= r_d.dat[6:0];
                                end else begin
                                    r_cursor   <= '0;
                                    r_err_addr <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Off-screen reads are served from a flag so the memory address never leaves 0..79.
    assign w_raddr = (rd_idx <= LAST_CELL) ? rd_idx : 7'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oob <= 1'b1;
        end else begin
            r_oob <= (rd_idx > LAST_CELL);
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_q)
    );

    assign rd_char     = r_oob ? CLEAR_CHAR : w_mem_q;
    assign cursor      = r_cursor;
    assign disp_on     = r_disp_on;
    assign entry_inc   = r_entry_inc;
    assign func_ok     = r_func_ok;
    assign busy        = r_busy;
    assign cmd_strobe  = r_cmd_strobe;
    assign data_strobe = r_data_strobe;
    assign err_addr    = r_err_addr;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomised bench for lcd_bus_monitor: a screen-level model tracks the cursor as a
// position along the DDRAM line order and is compared against the DUT every cycle.
module tb_lcd_bus_monitor;

    localparam logic [7:0] CLR = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] rd_idx;
    logic [7:0] rd_char;
    logic [6:0] cursor;
    logic       disp_on, entry_inc, func_ok, busy;
    logic       cmd_strobe, data_strobe, err_addr;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    lcd_bus_monitor_if bus ();

    lcd_bus_monitor #(.CLEAR_CHAR(CLR)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rd_idx      (rd_idx),
        .rd_char     (rd_char),
        .cursor      (cursor),
        .disp_on     (disp_on),
        .entry_inc   (entry_inc),
        .func_ok     (func_ok),
        .busy        (busy),
        .cmd_strobe  (cmd_strobe),
        .data_strobe (data_strobe),
        .err_addr    (err_addr),
        .drop_cnt    (drop_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Screen model: cells by linear index, cursor as position 0..79 along DDRAM order.
    logic [7:0] m_mem [80];
    bit         m_known [80];
    int         m_p = 0, m_left = 80, m_drop = 0;
    bit         m_disp = 0, m_inc = 1, m_func = 0;
    bit         m_cstb = 0, m_dstb = 0, m_err = 0;
    logic [7:0] m_rd = CLR;
    bit         m_rd_known = 1, m_ready = 0;
    bit         pend = 0, pend_rs = 0, pend_rw = 0;
    logic [7:0] pend_dat = 8'h00;
    int         cnt_cmd = 0, cnt_data = 0, cnt_err = 0;
    bit         rd_force = 0;
    logic [6:0] rd_val = 7'd0;

    function automatic int ord_addr(input int p);
        return (p < 40) ? p : ('h40 + p - 40);
    endfunction

    function automatic int addr_to_lin(input int a);
        int b, row;
        if (a < 'h40) begin b = a;         row = (b / 20) * 2;     end
        else          begin b = a - 'h40;  row = (b / 20) * 2 + 1; end
        return row * 20 + (b % 20);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmd(input logic [7:0] d);
        int hb, a;
        hb = -1;
        for (int b = 7; b >= 0; b--) if (hb < 0 && d[b]) hb = b;
        m_cstb = 1;
        case (hb)
            0: begin m_left = 80; m_p = 0; m_inc = 1; end
            1: m_p = 0;
            2: m_inc = d[1];
            3: m_disp = d[2];
            4: if (!d[3]) m_p = d[2] ? (m_p + 1) % 80 : (m_p + 79) % 80;
            5: m_func = d[4] & d[3];
            7: begin
                a = int'(d[6:0]);
                if (a < 'h28) m_p = a;
                else if (a >= 'h40 && a < 'h68) m_p = a - 'h40 + 40;
                else begin m_p = 0; m_err = 1; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        bit busy_before;
        int lin;
        #1;
        if (!rst) begin
            m_p = 0; m_disp = 0; m_inc = 1; m_func = 0; m_left = 80; m_drop = 0;
            m_cstb = 0; m_dstb = 0; m_err = 0; m_rd = CLR; m_rd_known = 1; pend = 0;
            m_ready = 1;
        end else begin
            if (rd_idx >= 7'd80) begin m_rd = CLR; m_rd_known = 1; end
            else begin m_rd = m_mem[rd_idx]; m_rd_known = m_known[rd_idx]; end
            m_cstb = 0; m_dstb = 0; m_err = 0;
            busy_before = (m_left > 0);
            if (busy_before) begin
                m_mem[80 - m_left] = CLR;
                m_known[80 - m_left] = 1;
                m_left--;
            end
            if (pend) begin
                pend = 0;
                if (!pend_rw) begin
                    if (busy_before) begin
                        if (m_drop < 255) m_drop++;
                    end else if (pend_rs) begin
                        lin = addr_to_lin(ord_addr(m_p));
                        m_mem[lin] = pend_dat;
                        m_known[lin] = 1;
                        m_dstb = 1;
                        m_p = m_inc ? (m_p + 1) % 80 : (m_p + 79) % 80;
                    end else begin
                        model_cmd(pend_dat);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_strobe)  cnt_cmd++;
        if (data_strobe) cnt_data++;
        if (err_addr)    cnt_err++;
        if (rst && m_ready) begin
            chk("busy", busy, (m_left > 0));
            chk("cursor", cursor, ord_addr(m_p));
            chk("disp_on", disp_on, m_disp);
            chk("entry_inc", entry_inc, m_inc);
            chk("func_ok", func_ok, m_func);
            chk("cmd_strobe", cmd_strobe, m_cstb);
            chk("data_strobe", data_strobe, m_dstb);
            chk("err_addr", err_addr, m_err);
            chk("drop_cnt", drop_cnt, m_drop);
            if (m_rd_known) chk("rd_char", rd_char, m_rd);
        end
    end

    initial begin
        rd_idx = 7'd0;
        forever begin
            @(negedge clk);
            rd_idx = rd_force ? rd_val : 7'($urandom_range(0, 95));
        end
    end

    task automatic wr_t(input bit rs, input bit rw, input logic [7:0] dat, input int hi, input int lo);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_dat = dat; bus.lcd_en = 1'b1;
        repeat (hi) @(negedge clk);
        bus.lcd_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        pend_rs = rs; pend_rw = rw; pend_dat = dat; pend = 1;
        repeat (lo) @(negedge clk);
        $display("tx rs=%0d rw=%0d dat=%02h", rs, rw, dat);
    endtask

    task automatic wr(input bit rs, input logic [7:0] dat);
        wr_t(rs, 1'b0, dat, 3, 3);
    endtask

    task automatic read_cell(input int idx, output logic [7:0] v);
        @(posedge clk);
        #2;
        rd_force = 1; rd_val = 7'(idx);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        v = rd_char;
        rd_force = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        chk("wait_idle", busy, 1'b0);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (busy !== 1'b0 && n < 200);
        chk(nm, n, 80);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int c0, d0, e0;
        bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_dat = 8'h00;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b1);
        chk("rst_cursor", cursor, 7'h00);
        chk("rst_entry_inc", entry_inc, 1'b1);
        chk("rst_disp_on", disp_on, 1'b0);
        chk("rst_drop", drop_cnt, 8'h00);
        chk("rst_rd_char", rd_char, CLR);
        @(posedge clk);
        #2 rst = 1'b1;
        count_busy("busy_len_reset");
        for (int i = 0; i < 80; i++) begin
            read_cell(i, v);
            chk("init_cell", v, CLR);
        end

        c0 = cnt_cmd; d0 = cnt_data;
        wr(0, 8'h80); wr(1, 8'h47);
        read_cell(0, v);            chk("cell0_47", v, 8'h47);
        chk("cursor_01", cursor, 7'h01);
        chk("one_cmd", cnt_cmd - c0, 1);
        chk("one_data", cnt_data - d0, 1);

        wr(0, 8'hE7); wr(1, 8'h4F);
        read_cell(79, v);           chk("cell79_4f", v, 8'h4F);
        chk("cursor_wrap", cursor, 7'h00);
        wr(0, 8'h04); wr(1, 8'h41);
        read_cell(0, v);            chk("cell0_41", v, 8'h41);
        chk("cursor_dec", cursor, 7'h67);

        wr(0, 8'h0C); wr(0, 8'h38);
        @(negedge clk);
        chk("disp_on_1", disp_on, 1'b1);
        chk("func_ok_1", func_ok, 1'b1);
        e0 = cnt_err;
        wr(0, 8'hA8);
        @(negedge clk);
        chk("err_once", cnt_err - e0, 1);
        chk("cursor_bad", cursor, 7'h00);

        wr(0, 8'h01); wr(1, 8'h58);
        wait_idle();
        chk("drop_1", drop_cnt, 8'd1);
        read_cell(0, v);            chk("cell0_cleared", v, CLR);

        c0 = cnt_cmd; d0 = cnt_data;
        wr_t(1, 1, 8'h99, 3, 3); wr_t(0, 1, 8'h01, 3, 3);
        @(negedge clk);
        chk("rw_no_cmd", cnt_cmd - c0, 0);
        chk("rw_no_data", cnt_data - d0, 0);
        chk("rw_busy", busy, 1'b0);

        for (int t = 0; t < 400; t++) begin
            bit rs, rw;
            logic [7:0] d;
            rs = 1'($urandom);
            rw = ($urandom_range(0, 9) == 0);
            d  = 8'($urandom);
            if (!rs && d == 8'h01 && $urandom_range(0, 3) != 0) d = 8'h02;
            if (!rs && $urandom_range(0, 29) == 0) d = 8'h01;
            wr_t(rs, rw, d, $urandom_range(3, 5), $urandom_range(1, 4));
        end
        wait_idle();

        for (int r = 0; r < 60 && m_drop < 255; r++) begin
            wr_t(0, 0, 8'h01, 3, 1);
            for (int k = 0; k < 10; k++) wr_t(1, 0, 8'($urandom), 3, 1);
            wait_idle();
        end
        chk("drop_sat", drop_cnt, 8'd255);
        wr(0, 8'h01); wr(1, 8'h11);
        wait_idle();
        chk("drop_hold", drop_cnt, 8'd255);

        wr(0, 8'h01);
        repeat (30) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midclr_busy", busy, 1'b1);
        chk("midclr_drop", drop_cnt, 8'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        count_busy("busy_len_midclear");
        read_cell(79, v);           chk("cell79_after", v, CLR);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
